// File: rtl/mcdt_demux.sv
// mcdt_demux: routes the merged MCDT stream by channel id into three
// first-word-fall-through FIFOs with valid/ready outputs.
// Ports:
//   clk, rstn                  clock (rising edge); asynchronous active-high reset
//   in_data/in_val/in_id       merged upstream word, valid and channel id (3 = illegal)
//   chN_data_o/chN_valid_o     head-of-FIFO word and not-empty flag
//   chN_ready_i                consumer accepts the head word
//   chN_count_o                FIFO occupancy 0..DEPTH
//   chN_ovf_o/chN_drop_cnt_o   dropped-word pulse and saturating drop count
//   id_err_o                   pulse for a valid word carrying id 3
//   chN_rcv_cnt_o              saturating accepted-word count; built only when the
//                              MCDT_DEMUX_STATS_EN macro is defined, otherwise 0
module mcdt_demux #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_val,
   input  logic [1:0]        in_id,
   output logic [DATA_W-1:0] ch0_data_o,
   output logic              ch0_valid_o,
   input  logic              ch0_ready_i,
   output logic [CNT_W-1:0]  ch0_count_o,
   output logic              ch0_ovf_o,
   output logic [15:0]       ch0_drop_cnt_o,
   output logic [15:0]       ch0_rcv_cnt_o,
   output logic [DATA_W-1:0] ch1_data_o,
   output logic              ch1_valid_o,
   input  logic              ch1_ready_i,
   output logic [CNT_W-1:0]  ch1_count_o,
   output logic              ch1_ovf_o,
   output logic [15:0]       ch1_drop_cnt_o,
   output logic [15:0]       ch1_rcv_cnt_o,
   output logic [DATA_W-1:0] ch2_data_o,
   output logic              ch2_valid_o,
   input  logic              ch2_ready_i,
   output logic [CNT_W-1:0]  ch2_count_o,
   output logic              ch2_ovf_o,
   output logic [15:0]       ch2_drop_cnt_o,
   output logic [15:0]       ch2_rcv_cnt_o,
   output logic              id_err_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);
   logic [2:0]              w_rdy;
   logic [2:0][DATA_W-1:0]  w_data;
   logic [2:0][CNT_W-1:0]   w_cnt;
   logic [2:0][15:0]        w_drop_cnt;
   logic [2:0][15:0]        w_rcv_cnt;
   logic [2:0]              w_ovf;
   logic                    r_err;
   assign w_rdy = {ch2_ready_i, ch1_ready_i, ch0_ready_i};
   always_ff @(posedge clk or posedge rstn)
      if (rstn) r_err <= 1'b0;
      else      r_err <= in_val && in_id == 2'd3;
   for (genvar g = 0; g < 3; g++) begin : g_ch
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_dout;
      logic [PW-1:0]     r_rd, r_wr, w_rd_nxt;
      logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
      logic [15:0]       r_drop;
      logic              r_ovf, w_hit, w_pop, w_push;
      // A full FIFO still accepts a word when its head leaves in the same cycle.
      always_comb begin
         w_hit     = in_val && in_id == 2'(g);
         w_pop     = r_cnt != '0 && w_rdy[g];
         w_push    = w_hit && (r_cnt != L_FULL || w_pop);
         w_rd_nxt  = w_pop ? r_rd + PW'(1) : r_rd;
         w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
      always_ff @(posedge clk)
         if (w_push) r_mem[r_wr] <= in_data;
      // The head register is loaded with the word that will be at the head after
      // this edge; when that slot is the one being written, bypass from in_data.
      // It keeps its value once the FIFO empties.
      always_ff @(posedge clk or posedge rstn)
         if (rstn) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_drop <= '0;
            r_ovf  <= 1'b0;
            r_dout <= '0;
         end else begin
            r_rd  <= w_rd_nxt;
            r_wr  <= w_push ? r_wr + PW'(1) : r_wr;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_hit && !w_push;
            if (w_hit && !w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            if (w_cnt_nxt != '0) r_dout <= (w_push && w_rd_nxt == r_wr) ? in_data : r_mem[w_rd_nxt];
         end
`ifdef MCDT_DEMUX_STATS_EN
      logic [15:0] r_rcv;
      always_ff @(posedge clk or posedge rstn)
         if (rstn) r_rcv <= '0;
         else if (w_push && r_rcv != 16'hFFFF) r_rcv <= r_rcv + 16'd1;
      assign w_rcv_cnt[g] = r_rcv;
`else
      assign w_rcv_cnt[g] = '0;
`endif
      assign w_data[g]     = r_dout;
      assign w_cnt[g]      = r_cnt;
      assign w_drop_cnt[g] = r_drop;
      assign w_ovf[g]      = r_ovf;
   end
   assign ch0_data_o     = w_data[0];
   assign ch1_data_o     = w_data[1];
   assign ch2_data_o     = w_data[2];
   assign ch0_count_o    = w_cnt[0];
   assign ch1_count_o    = w_cnt[1];
   assign ch2_count_o    = w_cnt[2];
   assign ch0_valid_o    = w_cnt[0] != '0;
   assign ch1_valid_o    = w_cnt[1] != '0;
   assign ch2_valid_o    = w_cnt[2] != '0;
   assign ch0_ovf_o      = w_ovf[0];
   assign ch1_ovf_o      = w_ovf[1];
   assign ch2_ovf_o      = w_ovf[2];
   assign ch0_drop_cnt_o = w_drop_cnt[0];
   assign ch1_drop_cnt_o = w_drop_cnt[1];
   assign ch2_drop_cnt_o = w_drop_cnt[2];
   assign ch0_rcv_cnt_o  = w_rcv_cnt[0];
   assign ch1_rcv_cnt_o  = w_rcv_cnt[1];
   assign ch2_rcv_cnt_o  = w_rcv_cnt[2];
   assign id_err_o       = r_err;
endmodule

// File: tb/tb_mcdt_demux.sv
// tb_mcdt_demux: table, directed and random checks of mcdt_demux against a queue model.
module tb_mcdt_demux;
   localparam int DEPTH = 32;
   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_val = 1'b0;
   logic [1:0]  in_id = '0;
   logic        rdy [3];
   logic [31:0] dat [3];
   logic        vld [3];
   logic [5:0]  cnt [3];
   logic        ovf [3];
   logic [15:0] drp [3];
   logic [15:0] rcv [3];
   logic        id_err;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mcdt_demux dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_val(in_val), .in_id(in_id),
      .ch0_data_o(dat[0]), .ch0_valid_o(vld[0]), .ch0_ready_i(rdy[0]), .ch0_count_o(cnt[0]),
      .ch0_ovf_o(ovf[0]), .ch0_drop_cnt_o(drp[0]), .ch0_rcv_cnt_o(rcv[0]),
      .ch1_data_o(dat[1]), .ch1_valid_o(vld[1]), .ch1_ready_i(rdy[1]), .ch1_count_o(cnt[1]),
      .ch1_ovf_o(ovf[1]), .ch1_drop_cnt_o(drp[1]), .ch1_rcv_cnt_o(rcv[1]),
      .ch2_data_o(dat[2]), .ch2_valid_o(vld[2]), .ch2_ready_i(rdy[2]), .ch2_count_o(cnt[2]),
      .ch2_ovf_o(ovf[2]), .ch2_drop_cnt_o(drp[2]), .ch2_rcv_cnt_o(rcv[2]),
      .id_err_o(id_err)
   );

   // Reference model: one queue per channel plus plain counters.
   logic [31:0] mq [3][$];
   int          mdrop [3];
   int          mrcv [3];
   logic        movf [3];
   logic [31:0] mhead [3];
   logic        merr;

   task automatic model_clear();
      for (int c = 0; c < 3; c++) begin
         mq[c].delete();
         mdrop[c] = 0;
         mrcv[c]  = 0;
         movf[c]  = 1'b0;
         mhead[c] = '0;
      end
      merr = 1'b0;
   endtask

   task automatic model_edge();
      for (int c = 0; c < 3; c++) begin
         bit pop, hit, acc;
         pop = mq[c].size() > 0 && rdy[c];
         hit = in_val && int'(in_id) == c;
         acc = hit && (mq[c].size() < DEPTH || pop);
         if (pop) void'(mq[c].pop_front());
         if (acc) begin
            mq[c].push_back(in_data);
            if (mrcv[c] < 65535) mrcv[c]++;
         end
         movf[c] = hit && !acc;
         if (movf[c] && mdrop[c] < 65535) mdrop[c]++;
         if (mq[c].size() > 0) mhead[c] = mq[c][0];
      end
      merr = in_val && in_id == 2'd3;
   endtask

   task automatic chk(string n, int c, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ch%0d got %h expected %h at %0t", n, c, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         int er;
`ifdef MCDT_DEMUX_STATS_EN
         er = mrcv[c];
`else
         er = 0;
`endif
         chk("valid", c, 32'(vld[c]), 32'(mq[c].size() > 0));
         chk("count", c, 32'(cnt[c]), 32'(mq[c].size()));
         chk("data", c, dat[c], mhead[c]);
         chk("ovf", c, 32'(ovf[c]), 32'(movf[c]));
         chk("drop_cnt", c, 32'(drp[c]), 32'(mdrop[c]));
         chk("rcv_cnt", c, 32'(rcv[c]), 32'(er));
      end
      chk("id_err", 3, 32'(id_err), 32'(merr));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(logic v, logic [1:0] id, logic [31:0] d, logic [2:0] r);
      in_val = v; in_id = id; in_data = d;
      rdy[0] = r[0]; rdy[1] = r[1]; rdy[2] = r[2];
   endtask

   // Called just after a rising edge; reset acts before the next edge arrives.
   task automatic do_reset();
      drive(1'b1, 2'd0, 32'h1234_5678, 3'b000);
      rstn = 1'b1;
      #1;
      model_clear();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      drive(1'b0, 2'd0, '0, 3'b000);
      rstn = 1'b0;
   endtask

   typedef struct {
      logic        v;
      logic [1:0]  id;
      logic [31:0] d;
      logic [2:0]  r;
      int          c0, c1, c2;
      logic        err;
   } vec_t;

   vec_t tbl [9];
   int   pulses;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rdy[0] = 1'b0; rdy[1] = 1'b0; rdy[2] = 1'b0;
      model_clear();
      @(posedge clk); #1;
      do_reset();

      tbl[0] = '{1'b1, 2'd0, 32'h11, 3'b000, 1, 0, 0, 1'b0};
      tbl[1] = '{1'b1, 2'd1, 32'h22, 3'b000, 1, 1, 0, 1'b0};
      tbl[2] = '{1'b1, 2'd3, 32'h33, 3'b000, 1, 1, 0, 1'b1};
      tbl[3] = '{1'b1, 2'd2, 32'h44, 3'b001, 0, 1, 1, 1'b0};
      tbl[4] = '{1'b1, 2'd0, 32'h55, 3'b110, 1, 0, 0, 1'b0};
      tbl[5] = '{1'b0, 2'd0, 32'h0,  3'b111, 0, 0, 0, 1'b0};
      tbl[6] = '{1'b1, 2'd1, 32'h66, 3'b010, 0, 1, 0, 1'b0};
      tbl[7] = '{1'b1, 2'd1, 32'h77, 3'b010, 0, 1, 0, 1'b0};
      tbl[8] = '{1'b0, 2'd0, 32'h0,  3'b111, 0, 0, 0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].r);
         step();
         chk("tbl_cnt0", 0, 32'(cnt[0]), 32'(tbl[i].c0));
         chk("tbl_cnt1", 1, 32'(cnt[1]), 32'(tbl[i].c1));
         chk("tbl_cnt2", 2, 32'(cnt[2]), 32'(tbl[i].c2));
         chk("tbl_err", 3, 32'(id_err), 32'(tbl[i].err));
      end

      // In-order delivery on channel 0, one cycle latency.
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 2'd0, 32'h00C0_0000 + 32'(i), 3'b001);
         step();
         chk("inorder_data", 0, dat[0], 32'h00C0_0000 + 32'(i));
         chk("inorder_ch1_valid", 1, 32'(vld[1]), 32'd0);
         chk("inorder_ch2_valid", 2, 32'(vld[2]), 32'd0);
      end
      drive(1'b0, 2'd0, '0, 3'b001);
      step();

      // Overflow on channel 1, then drain.
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 2'd1, 32'h00C1_0000 + 32'(i), 3'b000);
         step();
         pulses += int'(ovf[1]);
      end
      chk("ovf_count", 1, 32'(cnt[1]), 32'd32);
      chk("ovf_pulses", 1, 32'(pulses), 32'd8);
      chk("ovf_drop_cnt", 1, 32'(drp[1]), 32'd8);
      drive(1'b0, 2'd0, '0, 3'b010);
      for (int i = 0; i < 32; i++) begin
         chk("drain_data", 1, dat[1], 32'h00C1_0000 + 32'(i));
         step();
      end
      chk("drain_count", 1, 32'(cnt[1]), 32'd0);

      // Full FIFO 2 accepts a word when popped in the same cycle.
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 2'd2, 32'h00C2_0000 + 32'(i), 3'b000);
         step();
      end
      drive(1'b1, 2'd2, 32'h00C2_00AA, 3'b100);
      step();
      chk("fullpop_count", 2, 32'(cnt[2]), 32'd32);
      chk("fullpop_ovf", 2, 32'(ovf[2]), 32'd0);
      chk("fullpop_head", 2, dat[2], 32'h00C2_0001);

      // Illegal id.
      drive(1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000);
      step();
      chk("illegal_err", 3, 32'(id_err), 32'd1);
      chk("illegal_cnt2", 2, 32'(cnt[2]), 32'd32);
      drive(1'b0, 2'd0, '0, 3'b000);
      step();
      chk("illegal_err_clear", 3, 32'(id_err), 32'd0);

      // Reset while channel 2 is mid-drain.
      drive(1'b0, 2'd0, '0, 3'b100);
      repeat (5) step();
      do_reset();
      chk("rst_count2", 2, 32'(cnt[2]), 32'd0);
      drive(1'b1, 2'd2, 32'h0000_5A5A, 3'b000);
      step();
      chk("post_rst_push", 2, dat[2], 32'h0000_5A5A);
      drive(1'b0, 2'd0, '0, 3'b111);
      step();

      // Receive statistics: 100 words per channel, none dropped.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 2'(i % 3), 32'(i), 3'b111);
         step();
      end
      drive(1'b0, 2'd0, '0, 3'b111);
      step();
      for (int c = 0; c < 3; c++) begin
`ifdef MCDT_DEMUX_STATS_EN
         chk("stats_rcv", c, 32'(rcv[c]), 32'd100);
`else
         chk("stats_rcv", c, 32'(rcv[c]), 32'd0);
`endif
      end

      // Random traffic; the first phase starves consumers to force drops.
      for (int i = 0; i < 3000; i++) begin
         int lo;
         lo = (i < 1500) ? 3 : 1;
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
               {1'($urandom_range(0, 3) >= lo), 1'($urandom_range(0, 3) >= lo), 1'($urandom_range(0, 3) >= lo)});
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
